reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  Parametrised, clocked successor to the one-hot register bank. Holds NUM_REGS x DATA_W registers.
//  Provides one ALU write-back port, one memory-load return port with a valid/ready handshake, and
//  two asynchronous read ports.
//  A per-register busy scoreboard tracks outstanding loads so decode can stall on RAW hazards.
//  Sits between decode/execute and the load/store unit in the CPU datapath.
// PARAMETERS
//  DATA_W    32   register width in bits
//  NUM_REGS  16   register count (power of two, >=2)
//  ADDR_W    4    register index width, = $clog2(NUM_REGS)
// PORTS
//  clk         in   1         single clock, all state updates on rising edge
//  reset_n     in   1         synchronous reset, active-low
//  wr_en       in   1         ALU write-back strobe
//  wr_addr     in   ADDR_W    ALU write-back register index
//  wr_data     in   DATA_W    ALU write-back data
//  ld_issue    in   1         load issued; marks ld_issue_addr busy
//  ld_issue_addr in ADDR_W    destination of issued load
//  ld_valid    in   1         load return data valid
//  ld_ready    out  1         block accepts load return (transfer = ld_valid & ld_ready)
//  ld_addr     in   ADDR_W    destination of returning load
//  ld_data     in   DATA_W    returning load data
//  rd_addr_a   in   ADDR_W    read port A index;  rd_data_a out DATA_W;  rd_busy_a out 1
//  rd_addr_b   in   ADDR_W    read port B index;  rd_data_b out DATA_W;  rd_busy_b out 1
//  busy        out  NUM_REGS  scoreboard vector, bit i = register i awaiting load
//  err         out  1         sticky hazard/protocol error flag
// BEHAVIOUR
//  Reset (reset_n=0 at edge): all registers 0, busy 0, err 0, ld_ready 0.
//  ld_ready registered: 0 in reset cycle and first cycle after release, then 1 permanently.
//  Writes: wr_en or load transfer updates the array at the edge; new value readable the next cycle.
//  Reads: combinational from array; rd_busy_x = busy[rd_addr_x]; both ports may alias any index.
//  Scoreboard, per register i, evaluated each edge:
//   - ld_issue to i: busy[i] <= 1. If busy[i] already 1 (second outstanding load): err <= 1.
//   - load transfer to i: data written, busy[i] <= 0, unless ld_issue to i in the same cycle
//     (new load wins, busy stays 1).
//   - load transfer to a non-busy i: data still written, err <= 1.
//  ALU write to a busy register (WAW): data written, busy unchanged, err <= 1.
//  wr_en and load transfer to the same index in one cycle: load data wins, err <= 1.
//  wr_en and load transfer to different indices: both written.
//  err clears only on reset. A reset mid-load drops all pending state; later returns set err.
// CONFIGURATION
//  WR_BYPASS_EN defined: read ports forward same-cycle write data.
//   - Load transfer data if ld_addr matches, else wr_data if wr_en and wr_addr match.
//   - rd_busy_x reads 0 when the matching load transfer is forwarded and no same-cycle ld_issue
//     targets that index.
//  WR_BYPASS_EN undefined: reads return the pre-edge array value and the pre-edge busy bit.
// STRUCTURE
//  Package reg_file_pkg holds:
//   - DATA_W and NUM_REGS defaults;
//   - typedef reg_idx_t (ADDR_W bits) and reg_word_t (DATA_W bits);
//   - a localparam for the ld_ready start-up delay.
//  One sub-module, reg_scoreboard, owns busy[] and err. Inputs: issue/transfer/write strobes and
//  indices. Outputs: busy, err.
//  Top level holds the array, write-priority mux, read muxes and bypass.
// TESTING
//  1 reset, then read all 16 on A/B -> all 0, busy=0, err=0; ld_ready=0 for 1 cycle after release, then 1.
//  2 wr_en r3=0xDEADBEEF -> next cycle rd_data_a(3)=0xDEADBEEF;
//    same cycle rd_data_a = 0xDEADBEEF with bypass, old 0 without.
//  3 ld_issue r5; 3 cycles later transfer 0x12345678 -> busy[5]=1 and rd_busy_b=1 meanwhile;
//    after transfer busy[5]=0, r5=0x12345678, err=0.
//  4 wr_en r7=0x1 and load transfer r7=0x2 same cycle (r7 busy) -> r7=0x2, busy[7]=0, err=1.
//  5 ld_issue r2 twice without return -> err=1; busy[2]=1.
//    Same-cycle issue and transfer on r2 -> busy[2] stays 1.
//  6 ld_issue r9, assert reset_n=0 one cycle, then transfer r9=0xAA -> r9=0xAA, busy[9]=0, err=1.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared sizing, types and start-up timing for the scoreboarded register file.
// WR_BYPASS_EN (optional) enables same-cycle write forwarding in reg_file_sb.
package reg_file_pkg;

   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 16;
   localparam int ADDR_W   = $clog2(NUM_REGS);

   // Edges after reset release before ld_ready rises.
   localparam int LD_READY_DLY = 2;

   typedef logic [ADDR_W-1:0] reg_idx_t;
   typedef logic [DATA_W-1:0] reg_word_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy tracking for outstanding loads plus a sticky error flag.
// A new issue beats a same-cycle return so the later load keeps ownership.
module reg_scoreboard
   import reg_file_pkg::*;
#(
   parameter int NUM_REGS = reg_file_pkg::NUM_REGS,
   parameter int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                issue,
   input  logic [ADDR_W-1:0]   issue_idx,
   input  logic                xfer,
   input  logic [ADDR_W-1:0]   xfer_idx,
   input  logic                wr,
   input  logic [ADDR_W-1:0]   wr_idx,
   output logic [NUM_REGS-1:0] busy,
   output logic                err
);

   logic [NUM_REGS-1:0] busy_nxt;
   logic                err_set;

   always_comb begin
      busy_nxt = busy;
      err_set  = 1'b0;
      if (wr && xfer && (wr_idx == xfer_idx))
         err_set = 1'b1;
      for (int i = 0; i < NUM_REGS; i++) begin
         logic iss_i, xfr_i, wr_i;
         iss_i = issue && (issue_idx == ADDR_W'(i));
         xfr_i = xfer && (xfer_idx == ADDR_W'(i));
         wr_i  = wr && (wr_idx == ADDR_W'(i));
         if ((iss_i || wr_i) && busy[i])
            err_set = 1'b1;
         if (xfr_i && !busy[i])
            err_set = 1'b1;
         if (iss_i)
            busy_nxt[i] = 1'b1;
         else if (xfr_i)
            busy_nxt[i] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         busy <= '0;
         err  <= 1'b0;
      end else begin
         busy <= busy_nxt;
         err  <= err | err_set;
      end
   end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with ALU write-back, handshaked load return and busy scoreboard.
// Define WR_BYPASS_EN to forward same-cycle write data onto the read ports.
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = reg_file_pkg::DATA_W,
   parameter int NUM_REGS = reg_file_pkg::NUM_REGS,
   parameter int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic                ld_issue,
   input  logic [ADDR_W-1:0]   ld_issue_addr,
   input  logic                ld_valid,
   output logic                ld_ready,
   input  logic [ADDR_W-1:0]   ld_addr,
   input  logic [DATA_W-1:0]   ld_data,
   input  logic [ADDR_W-1:0]   rd_addr_a,
   output logic [DATA_W-1:0]   rd_data_a,
   output logic                rd_busy_a,
   input  logic [ADDR_W-1:0]   rd_addr_b,
   output logic [DATA_W-1:0]   rd_data_b,
   output logic                rd_busy_b,
   output logic [NUM_REGS-1:0] busy,
   output logic                err
);

   logic [DATA_W-1:0]       regs [NUM_REGS];
   logic [LD_READY_DLY-1:0] rdy_sr;
   logic                    ld_xfer;

   assign ld_xfer  = ld_valid & ld_ready;
   assign ld_ready = rdy_sr[LD_READY_DLY-1];

   always_ff @(posedge clk) begin
      if (!reset_n)
         rdy_sr <= '0;
      else
         rdy_sr <= {rdy_sr[LD_READY_DLY-2:0], 1'b1};
   end

   // Load return is written last so it wins an index collision.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
      end else begin
         if (wr_en)
            regs[wr_addr] <= wr_data;
         if (ld_xfer)
            regs[ld_addr] <= ld_data;
      end
   end

   reg_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
   ) u_sb (
      .clk       (clk),
      .reset_n   (reset_n),
      .issue     (ld_issue),
      .issue_idx (ld_issue_addr),
      .xfer      (ld_xfer),
      .xfer_idx  (ld_addr),
      .wr        (wr_en),
      .wr_idx    (wr_addr),
      .busy      (busy),
      .err       (err)
   );

`ifdef WR_BYPASS_EN
   function automatic logic [DATA_W-1:0] fwd_data(input logic [ADDR_W-1:0] a);
      if (ld_xfer && (ld_addr == a))
         return ld_data;
      else if (wr_en && (wr_addr == a))
         return wr_data;
      else
         return regs[a];
   endfunction

   function automatic logic fwd_busy(input logic [ADDR_W-1:0] a);
      if (ld_xfer && (ld_addr == a) && !(ld_issue && (ld_issue_addr == a)))
         return 1'b0;
      else
         return busy[a];
   endfunction

   always_comb begin
      rd_data_a = fwd_data(rd_addr_a);
      rd_data_b = fwd_data(rd_addr_b);
      rd_busy_a = fwd_busy(rd_addr_a);
      rd_busy_b = fwd_busy(rd_addr_b);
   end
`else
   always_comb begin
      rd_data_a = regs[rd_addr_a];
      rd_data_b = regs[rd_addr_b];
      rd_busy_a = busy[rd_addr_a];
      rd_busy_b = busy[rd_addr_b];
   end
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: reset, write, load, hazard and error cases.
// Same-cycle read expectations follow the WR_BYPASS_EN build option.
module tb_reg_file_sb;
   import reg_file_pkg::*;

   logic                clk = 1'b0;
   logic                reset_n;
   logic                wr_en;
   reg_idx_t            wr_addr;
   reg_word_t           wr_data;
   logic                ld_issue;
   reg_idx_t            ld_issue_addr;
   logic                ld_valid;
   logic                ld_ready;
   reg_idx_t            ld_addr;
   reg_word_t           ld_data;
   reg_idx_t            rd_addr_a;
   reg_word_t           rd_data_a;
   logic                rd_busy_a;
   reg_idx_t            rd_addr_b;
   reg_word_t           rd_data_b;
   logic                rd_busy_b;
   logic [NUM_REGS-1:0] busy;
   logic                err;

   int n_chk  = 0;
   int n_pass = 0;

`ifdef WR_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   reg_file_sb dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .ld_issue      (ld_issue),
      .ld_issue_addr (ld_issue_addr),
      .ld_valid      (ld_valid),
      .ld_ready      (ld_ready),
      .ld_addr       (ld_addr),
      .ld_data       (ld_data),
      .rd_addr_a     (rd_addr_a),
      .rd_data_a     (rd_data_a),
      .rd_busy_a     (rd_busy_a),
      .rd_addr_b     (rd_addr_b),
      .rd_data_b     (rd_data_b),
      .rd_busy_b     (rd_busy_b),
      .busy          (busy),
      .err           (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] req);
      n_chk++;
      assert (obs === req) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, req);
   endtask

   initial begin
      reset_n = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      ld_issue = 1'b0; ld_issue_addr = '0;
      ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
      rd_addr_a = '0; rd_addr_b = '0;

      // 1: reset state
      tick();
      check("rst_ready", 32'(ld_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      for (int i = 0; i < NUM_REGS; i++) begin
         rd_addr_a = reg_idx_t'(i);
         rd_addr_b = reg_idx_t'(NUM_REGS - 1 - i);
         #1;
         check("rst_rd_a", rd_data_a, 32'd0);
         check("rst_rd_b", rd_data_b, 32'd0);
      end
      reset_n = 1'b1;
      tick();
      check("ready_rel1", 32'(ld_ready), 32'd0);
      tick();
      check("ready_rel2", 32'(ld_ready), 32'd1);

      // 2: ALU write r3
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEADBEEF;
      rd_addr_a = 4'd3;
      #1;
      check("wr_same", rd_data_a, BYP ? 32'hDEADBEEF : 32'd0);
      tick();
      wr_en = 1'b0;
      #1;
      check("wr_next", rd_data_a, 32'hDEADBEEF);

      // 3: load r5
      ld_issue = 1'b1; ld_issue_addr = 4'd5;
      tick();
      ld_issue = 1'b0;
      rd_addr_b = 4'd5;
      #1;
      check("ld_busy_vec", 32'(busy), 32'h0020);
      check("ld_rd_busy_b", 32'(rd_busy_b), 32'd1);
      tick();
      tick();
      check("ld_busy_hold", 32'(busy[5]), 32'd1);
      ld_valid = 1'b1; ld_addr = 4'd5; ld_data = 32'h12345678;
      #1;
      check("ld_same_busy", 32'(rd_busy_b), BYP ? 32'd0 : 32'd1);
      check("ld_same_data", rd_data_b, BYP ? 32'h12345678 : 32'd0);
      tick();
      ld_valid = 1'b0;
      #1;
      check("ld_done_busy", 32'(busy), 32'd0);
      check("ld_done_data", rd_data_b, 32'h12345678);
      check("ld_done_err", 32'(err), 32'd0);

      // 4: ALU write and load return collide on busy r7
      ld_issue = 1'b1; ld_issue_addr = 4'd7;
      tick();
      ld_issue = 1'b0;
      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h1;
      ld_valid = 1'b1; ld_addr = 4'd7; ld_data = 32'h2;
      tick();
      wr_en = 1'b0; ld_valid = 1'b0;
      rd_addr_a = 4'd7;
      #1;
      check("coll_data", rd_data_a, 32'h2);
      check("coll_busy", 32'(busy[7]), 32'd0);
      check("coll_err", 32'(err), 32'd1);

      // 5: double issue on r2, then issue + return same cycle
      ld_issue = 1'b1; ld_issue_addr = 4'd2;
      tick();
      tick();
      check("dbl_err", 32'(err), 32'd1);
      check("dbl_busy", 32'(busy[2]), 32'd1);
      ld_valid = 1'b1; ld_addr = 4'd2; ld_data = 32'h55;
      rd_addr_a = 4'd2;
      #1;
      check("iss_xfer_rdbusy", 32'(rd_busy_a), 32'd1);
      tick();
      ld_issue = 1'b0; ld_valid = 1'b0;
      #1;
      check("iss_xfer_busy", 32'(busy[2]), 32'd1);
      check("iss_xfer_data", rd_data_a, 32'h55);

      // ALU write and load return to different indices
      wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'h11;
      ld_valid = 1'b1; ld_addr = 4'd4; ld_data = 32'h44;
      tick();
      wr_en = 1'b0; ld_valid = 1'b0;
      rd_addr_a = 4'd1; rd_addr_b = 4'd4;
      #1;
      check("dual_wr", rd_data_a, 32'h11);
      check("dual_ld", rd_data_b, 32'h44);

      // 6: reset drops pending r9 load
      ld_issue = 1'b1; ld_issue_addr = 4'd9;
      tick();
      ld_issue = 1'b0;
      check("pre_rst_busy", 32'(busy), 32'h0204);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      rd_addr_a = 4'd3;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_err", 32'(err), 32'd0);
      check("mid_rst_r3", rd_data_a, 32'd0);
      check("mid_rst_ready", 32'(ld_ready), 32'd0);
      tick();
      check("mid_rel1", 32'(ld_ready), 32'd0);
      tick();
      check("mid_rel2", 32'(ld_ready), 32'd1);
      ld_valid = 1'b1; ld_addr = 4'd9; ld_data = 32'hAA;
      tick();
      ld_valid = 1'b0;
      rd_addr_b = 4'd9;
      #1;
      check("stale_data", rd_data_b, 32'hAA);
      check("stale_busy", 32'(busy[9]), 32'd0);
      check("stale_err", 32'(err), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
